// File: rtl/hazard_ctrl.sv
// hazard_ctrl: hazard detection, operand forwarding and perf counters for a 5-stage RISC-V pipeline.
// Tracks E/M/W register tags internally and advances them with the stalls/flushes it drives.
module hazard_ctrl #(
    parameter int          REG_AW   = 5,
    parameter int          CNT_W    = 16,
    parameter logic [1:0]  LOAD_SRC = 2'b01
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [REG_AW-1:0] Rs1D,
    input  logic [REG_AW-1:0] Rs2D,
    input  logic [REG_AW-1:0] RdD,
    input  logic              RegWriteD,
    input  logic [1:0]        ResultSrcD,
    input  logic              PCSrcE,
    input  logic              DmemBusy,
    input  logic              CntClr,
    output logic [1:0]        ForwardAE,
    output logic [1:0]        ForwardBE,
    output logic              StallF,
    output logic              StallD,
    output logic              StallE,
    output logic              StallM,
    output logic              StallW,
    output logic              FlushD,
    output logic              FlushE,
    output logic [CNT_W-1:0]  LwStallCnt,
    output logic [CNT_W-1:0]  FlushCnt
);
    logic [REG_AW-1:0] rs1_e, rs2_e, rd_e, rd_m, rd_w;
    logic              rw_e, ld_e, rw_m, rw_w;
    logic              lw_raw, lw_stall, flush_e;

    function automatic logic [1:0] fwd(input logic [REG_AW-1:0] src);
        return (rw_m && rd_m != '0 && rd_m == src) ? 2'b10 :
               (rw_w && rd_w != '0 && rd_w == src) ? 2'b01 : 2'b00;
    endfunction

    assign lw_raw   = ld_e && rd_e != '0 && (rd_e == Rs1D || rd_e == Rs2D);
    assign lw_stall = lw_raw && !PCSrcE;
    assign flush_e  = !DmemBusy && (lw_stall || PCSrcE);

    // Every output is gated by reset_n so the pipeline sees all zeros while held in reset.
    assign StallF    = reset_n && (DmemBusy || lw_stall);
    assign StallD    = StallF;
    assign StallE    = reset_n && DmemBusy;
    assign StallM    = StallE;
    assign StallW    = StallE;
    assign FlushD    = reset_n && !DmemBusy && PCSrcE;
    assign FlushE    = reset_n && flush_e;
    assign ForwardAE = reset_n ? fwd(rs1_e) : 2'b00;
    assign ForwardBE = reset_n ? fwd(rs2_e) : 2'b00;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            {rs1_e, rs2_e, rd_e, rw_e, ld_e} <= '0;
            {rd_m, rw_m, rd_w, rw_w}         <= '0;
        end else if (!DmemBusy) begin
            {rd_w, rw_w} <= {rd_m, rw_m};
            {rd_m, rw_m} <= {rd_e, rw_e};
            {rs1_e, rs2_e, rd_e, rw_e, ld_e} <= flush_e ? '0 :
                {Rs1D, Rs2D, RdD, RegWriteD, ResultSrcD == LOAD_SRC};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            LwStallCnt <= '0;
            FlushCnt   <= '0;
        end else if (CntClr) begin
            LwStallCnt <= '0;
            FlushCnt   <= '0;
        end else begin
            if (lw_stall && !DmemBusy && !(&LwStallCnt))
                LwStallCnt <= LwStallCnt + 1'b1;
            if (PCSrcE && !DmemBusy && !(&FlushCnt))
                FlushCnt <= FlushCnt + 1'b1;
        end
    end
endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Hazard and forwarding controller for the 5-stage RISC-V pipeline.
- Keeps its own shadow copy of the E/M/W stage register tags (rs/rd/regwrite/load), fed from decode-stage fields and updated with the stall/flush it generates.
- Drives the ALU-operand forwarding mux3 selects, the per-stage stall enables and the flush clears.
- Holds saturating performance counters for load-use stalls and branch flushes.

Parameters:
REG_AW, 5, register-index width
CNT_W, 16, performance counter width
LOAD_SRC, 2'b01, ResultSrcD encoding that marks a load

Ports:
clk  in  1  pipeline clock
reset_n  in  1  asynchronous active-low reset
Rs1D  in  REG_AW  decode-stage source register 1
Rs2D  in  REG_AW  decode-stage source register 2
RdD  in  REG_AW  decode-stage destination register
RegWriteD  in  1  decode-stage instruction writes rd
ResultSrcD  in  2  decode-stage result select (load when == LOAD_SRC)
PCSrcE  in  1  branch/jump taken, resolved in execute
DmemBusy  in  1  data memory not ready; freezes whole pipeline
CntClr  in  1  synchronous clear of both counters
ForwardAE  out  2  SrcA mux3 select: 00 regfile, 01 ResultW, 10 ALUResultM
ForwardBE  out  2  SrcB mux3 select, same encoding
StallF  out  1  hold PC
StallD  out  1  hold IF/ID register
StallE  out  1  hold ID/EX register
StallM  out  1  hold EX/MEM register
StallW  out  1  hold MEM/WB register
FlushD  out  1  clear IF/ID register
FlushE  out  1  clear ID/EX register
LwStallCnt  out  CNT_W  load-use stall cycles, saturating
FlushCnt  out  CNT_W  branch flush events, saturating

Behaviour:
- Shadow state: rs1E, rs2E, rdE, rwE, ldE; rdM, rwM; rdW, rwW.
- Reset (async, reset_n low): all shadow state and counters = 0. All outputs = 0 while reset_n is low, including combinational ones. Deassertion is synchronous to clk.
- lwRaw = ldE & (rdE != 0) & ((rdE == Rs1D) | (rdE == Rs2D)).
- lwStall = lwRaw & ~PCSrcE. A squashed D instruction never stalls.

Combinational outputs:
- If DmemBusy: StallF..StallW = 1; FlushD = FlushE = 0.
- Else:
  - StallF = StallD = lwStall; StallE = StallM = StallW = 0.
  - FlushD = PCSrcE.
  - FlushE = lwStall | PCSrcE.
- ForwardAE = 10 if rwM & rdM != 0 & rdM == rs1E; else 01 if rwW & rdW != 0 & rdW == rs1E; else 00.
- ForwardBE is identical using rs2E. M has priority over W. 11 is never produced. x0 is never forwarded.
- Forwarding is valid during DmemBusy, computed from the held shadow state.

Sequential update at each posedge, when not in reset:
- DmemBusy = 1: all shadow state holds.
- Otherwise the W, M and E tags advance:
  - W <= M.
  - M <= {rdE, rwE}.
  - If FlushE: E <= bubble (all fields 0). Else E <= {Rs1D, Rs2D, RdD, RegWriteD, ResultSrcD == LOAD_SRC}.
  - FlushD needs no internal state: the D fields arriving next cycle are already zeroed by the datapath.
- Counters:
  - CntClr has the highest priority and zeroes both counters.
  - Else LwStallCnt += 1 on each cycle with lwStall & ~DmemBusy, saturating at all-ones.
  - Else FlushCnt += 1 on each cycle with PCSrcE & ~DmemBusy, saturating at all-ones.
- Simultaneous PCSrcE and lwRaw: flush wins. FlushD = FlushE = 1, no stall, LwStallCnt unchanged.
- Reset mid-stall: all state clears immediately; the next post-reset cycle has no stall and no forwarding.
- Latency: stall and forward decisions are combinational, same cycle. Shadow tags lag the datapath by 0 cycles; they update on the same edge as the pipeline registers.

Test Plan:
1. RAW on M: add x5 (RegWriteD=1, RdD=5), then sub using Rs1D=5 one cycle later. When sub is in E: ForwardAE=10, ForwardBE=00, no stall.
2. RAW on W: writer to x7, one independent instruction, then reader with Rs2D=7. Reader in E: ForwardBE=01. Writer with RdD=0 instead: ForwardBE=00.
3. Load-use: lw x3 (ResultSrcD=01), next instruction Rs1D=3. Exactly one cycle of StallF=StallD=FlushE=1. Next cycle ForwardAE=01. LwStallCnt=1.
4. Branch taken with a load-use pair behind it: PCSrcE=1 while lwRaw=1. FlushD=FlushE=1, StallF=StallD=0, FlushCnt=1, LwStallCnt=0.
5. DmemBusy held 3 cycles during a load-use condition. All five Stall*=1 and flushes 0 for 3 cycles; shadow state and counters unchanged. After release, the load-use stall occurs once.
6. Force LwStallCnt to 0xFFFF with 65535+2 stalls: it stays 0xFFFF. Pulse CntClr with a stall in the same cycle: reads 0. Assert reset_n low mid-operation: all outputs 0 asynchronously.
